fb_write_arbiter: RTL



---
 rtl/fb_write_arbiter_pkg.sv | 16 +
 rtl/fb_write_arbiter_if.sv | 30 +++
 rtl/fb_write_arbiter_clear_sweep.sv | 34 +++
 rtl/fb_write_arbiter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/fb_write_arbiter_pkg.sv
// Shared defaults and FSM state encoding for the frame-buffer write-port arbiter.
package fb_pkg;

    localparam int          FB_DATA_SIZE = 3;
    localparam int          FB_ADDR_SIZE = 16;
    localparam int          FB_PIX_COUNT = 65536;
    localparam int          FB_H_RES     = 256;
    localparam logic [2:0]  FB_CLR_COLOR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_BRUSH = 2'd2
    } fb_state_e;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester-side and RAM port-A signals of the frame-buffer write arbiter.
interface fb_write_arbiter_if
    import fb_pkg::*;
#(
    parameter int DATA_SIZE = FB_DATA_SIZE,
    parameter int ADDR_SIZE = FB_ADDR_SIZE
) ();

    logic                 pen_req;
    logic [ADDR_SIZE-1:0] pen_addr;
    logic [DATA_SIZE-1:0] pen_color;
    logic                 pen_ack;
    logic                 clr_req;
    logic                 clr_done;
    logic                 busy;
    logic                 we;
    logic [ADDR_SIZE-1:0] addr_a;
    logic [DATA_SIZE-1:0] din_a;

    modport slave (
        input  pen_req, pen_addr, pen_color, clr_req,
        output pen_ack, clr_done, busy, we, addr_a, din_a
    );

    modport master (
        output pen_req, pen_addr, pen_color, clr_req,
        input  pen_ack, clr_done, busy, we, addr_a, din_a
    );

endinterface

// File: rtl/fb_write_arbiter_clear_sweep.sv
// Clear-address counter: one bit wider than the address so a full 2**ADDR_SIZE sweep terminates.
module fb_clear_sweep
    import fb_pkg::*;
#(
    parameter int ADDR_SIZE = FB_ADDR_SIZE,
    parameter int PIX_COUNT = FB_PIX_COUNT
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_i,
    input  logic                 advance_i,
    output logic [ADDR_SIZE-1:0] addr_o,
    output logic                 done_o
);

    localparam logic [ADDR_SIZE:0] LAST_COUNT = (ADDR_SIZE+1)'(PIX_COUNT);
    localparam logic [ADDR_SIZE:0] ONE        = (ADDR_SIZE+1)'(1);

    logic [ADDR_SIZE:0] count_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (start_i) begin
            count_q <= '0;
        end else if (advance_i) begin
            count_q <= count_q + ONE;
        end
    end

    assign addr_o = count_q[ADDR_SIZE-1:0];
    assign done_o = (count_q == LAST_COUNT);

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares RAM write port A between pen writes and a full-screen clear; all outputs registered.
// Define FB_ARB_BRUSH2_EN to make each accepted pen request paint a 2x2 brush.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int                   DATA_SIZE = FB_DATA_SIZE,
    parameter int                   ADDR_SIZE = FB_ADDR_SIZE,
    parameter int                   PIX_COUNT = FB_PIX_COUNT,
`ifdef FB_ARB_BRUSH2_EN
    parameter int                   H_RES     = FB_H_RES,
`endif
    parameter logic [DATA_SIZE-1:0] CLR_COLOR = DATA_SIZE'(FB_CLR_COLOR)
) (
    input  logic              clk,
    input  logic              reset,
    fb_write_arbiter_if.slave bus
);

    fb_state_e            state_q, state_d;
    logic                 we_q, we_d;
    logic [ADDR_SIZE-1:0] addr_q, addr_d;
    logic [DATA_SIZE-1:0] din_q, din_d;
    logic                 ack_q, ack_d;
    logic                 done_q, done_d;

    logic                 sweep_start, sweep_advance, sweep_done;
    logic [ADDR_SIZE-1:0] sweep_addr;

`ifdef FB_ARB_BRUSH2_EN
    localparam logic [ADDR_SIZE-1:0] ROW_OFF = ADDR_SIZE'(H_RES);
    localparam logic [ADDR_SIZE-1:0] COL_OFF = ADDR_SIZE'(1);

    logic [ADDR_SIZE-1:0] base_q, base_d;
    logic [DATA_SIZE-1:0] color_q, color_d;
    logic [1:0]           step_q, step_d;
`endif

    fb_clear_sweep #(
        .ADDR_SIZE (ADDR_SIZE),
        .PIX_COUNT (PIX_COUNT)
    ) u_sweep (
        .clk       (clk),
        .reset     (reset),
        .start_i   (sweep_start),
        .advance_i (sweep_advance),
        .addr_o    (sweep_addr),
        .done_o    (sweep_done)
    );

    always_comb begin
        state_d       = state_q;
        we_d          = 1'b0;
        addr_d        = addr_q;
        din_d         = din_q;
        ack_d         = 1'b0;
        done_d        = 1'b0;
        sweep_start   = 1'b0;
        sweep_advance = 1'b0;
`ifdef FB_ARB_BRUSH2_EN
        base_d        = base_q;
        color_d       = color_q;
        step_d        = step_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // Clear wins; ack_q blocks re-accepting a request still held high.
                if (bus.clr_req) begin
                    state_d     = ST_CLEAR;
                    sweep_start = 1'b1;
                end else if (bus.pen_req && !ack_q) begin
                    we_d   = 1'b1;
                    addr_d = bus.pen_addr;
                    din_d  = bus.pen_color;
                    ack_d  = 1'b1;
`ifdef FB_ARB_BRUSH2_EN
                    state_d = ST_BRUSH;
                    base_d  = bus.pen_addr;
                    color_d = bus.pen_color;
                    step_d  = 2'd1;
`endif
                end
            end
            ST_CLEAR: begin
                if (sweep_done) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    we_d          = 1'b1;
                    addr_d        = sweep_addr;
                    din_d         = CLR_COLOR;
                    sweep_advance = 1'b1;
                end
            end
`ifdef FB_ARB_BRUSH2_EN
            ST_BRUSH: begin
                we_d   = 1'b1;
                din_d  = color_q;
                step_d = step_q + 2'd1;
                case (step_q)
                    2'd1:    addr_d = base_q + COL_OFF;
                    2'd2:    addr_d = base_q + ROW_OFF;
                    default: begin
                        addr_d  = base_q + ROW_OFF + COL_OFF;
                        state_d = ST_IDLE;
                    end
                endcase
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
        end
    end

`ifdef FB_ARB_BRUSH2_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q  <= '0;
            color_q <= '0;
            step_q  <= 2'd0;
        end else begin
            base_q  <= base_d;
            color_q <= color_d;
            step_q  <= step_d;
        end
    end
`endif

    assign bus.we       = we_q;
    assign bus.addr_a   = addr_q;
    assign bus.din_a    = din_q;
    assign bus.pen_ack  = ack_q;
    assign bus.clr_done = done_q;
    assign bus.busy     = (state_q != ST_IDLE);

endmodule
